// File: rtl/mem_port_arbiter_pkg.sv
// Shared opcode header for the memory port arbiter: RISC-V load/store func3
// encodings plus helpers for access sizing, alignment and load extraction.
package mem_port_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } access_size_e;

    function automatic access_size_e load_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            F3_LW:         return SZ_WORD;
            default:       return SZ_BAD;
        endcase
    endfunction

    function automatic access_size_e store_size(input logic [2:0] f3);
        case (f3)
            F3_SB:   return SZ_BYTE;
            F3_SH:   return SZ_HALF;
            F3_SW:   return SZ_WORD;
            default: return SZ_BAD;
        endcase
    endfunction

    // Unsupported encodings are reported through the misaligned error path.
    function automatic logic is_misaligned(input access_size_e sz, input logic [1:0] off);
        return (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00) || (sz == SZ_BAD);
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        // func3 bit 2 selects zero extension (LBU/LHU)
        case (load_size(f3))
            SZ_BYTE: return f3[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: return f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_store_align.sv
// Store lane steering: byte enables and shifted write data for SB/SH/SW,
// plus the misalignment flag for the current store request.
module mem_store_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  we,
    output logic [31:0] din,
    output logic        misaligned
);

    access_size_e size;

    assign size       = store_size(func3);
    assign misaligned = is_misaligned(size, offset);
    assign din        = wdata << {offset, 3'b000};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic hit;
            assign hit = (size == SZ_WORD) || (offset == LANE) ||
                         (size == SZ_HALF && (offset + 2'd1) == LANE);
            assign we[gi] = hit && !misaligned;
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between an
// instruction-fetch port and a load/store port, with one-cycle responses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_resp_valid,
    output logic [DATA_WIDTH-1:0] if_resp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_req_we,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    input  logic [2:0]            d_req_func3,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_err,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    logic        pref_d_reg;
    logic        grant_if;
    logic        grant_d;
    logic [3:0]  st_we;
    logic [31:0] st_din;
    logic        st_mis;
    logic        ld_mis;
    logic        d_mis;
    logic        if_pend_reg;
    logic        ld_pend_reg;
    logic        err_pend_reg;
    logic [2:0]  func3_reg;
    logic [1:0]  off_reg;
    logic        if_addr_unused;

    // Fetches are always word reads; the byte offset is ignored.
    assign if_addr_unused = ^if_req_addr[1:0];

    mem_store_align u_store_align (
        .func3      (d_req_func3),
        .offset     (d_req_addr[1:0]),
        .wdata      (d_req_wdata),
        .we         (st_we),
        .din        (st_din),
        .misaligned (st_mis)
    );

    assign ld_mis = is_misaligned(load_size(d_req_func3), d_req_addr[1:0]);
    assign d_mis  = d_req_we ? st_mis : ld_mis;

    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (!rst) begin
            grant_d  = d_req_valid && (!if_req_valid || pref_d_reg);
            grant_if = if_req_valid && !grant_d;
        end
    end

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 4'b0000;
        mem_addr = d_req_addr[ADDR_WIDTH-1:2];
        mem_din  = st_din;
        if (grant_if) begin
            mem_en   = 1'b1;
            mem_addr = if_req_addr[ADDR_WIDTH-1:2];
        end else if (grant_d && !d_mis) begin
            mem_en = 1'b1;
            if (d_req_we) begin
                mem_we = st_we;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref_d_reg   <= 1'b1;
            if_pend_reg  <= 1'b0;
            ld_pend_reg  <= 1'b0;
            err_pend_reg <= 1'b0;
            func3_reg    <= 3'b000;
            off_reg      <= 2'b00;
        end else begin
            // Pointer only moves when both requesters competed this cycle.
            if (if_req_valid && d_req_valid) begin
                pref_d_reg <= grant_if;
            end
            if_pend_reg  <= grant_if;
            ld_pend_reg  <= grant_d && !d_req_we && !d_mis;
            err_pend_reg <= grant_d && d_mis;
            if (grant_d) begin
                func3_reg <= d_req_func3;
                off_reg   <= d_req_addr[1:0];
            end
        end
    end

    assign if_resp_valid = if_pend_reg;
    assign if_resp_data  = mem_dout;
    assign d_resp_valid  = ld_pend_reg || err_pend_reg;
    assign d_resp_err    = err_pend_reg;
    assign d_resp_data   = ld_pend_reg ? load_extract(func3_reg, off_reg, mem_dout) : '0;

endmodule
